// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multi-cycle processor controller: opcodes, FSM
// states, ALU operation codes and the datapath select decode.
package proc_ctrl_pkg;

    localparam logic [4:0] OP_AR   = 5'h00;
    localparam logic [4:0] OP_T    = 5'h01;
    localparam logic [4:0] OP_I    = 5'h02;
    localparam logic [4:0] OP_J    = 5'h03;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] ALU_OP_FUNC = 4'h2;
    localparam logic [3:0] ALU_OP_ADD  = 4'h0;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WB, JUMP, HALTED, TRAP
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       sel_wr_reg;
        logic       sel_wr_data;
        logic       sel_alu_b;
    } ctrl_sel_t;

    // Datapath selects per instruction class; J, HALT and illegal opcodes use none.
    function automatic ctrl_sel_t decode_sel(input logic [4:0] opcode);
        ctrl_sel_t s;
        s = '0;
        case (opcode)
            OP_AR: s.alu_op = ALU_OP_FUNC;
            OP_I: begin
                s.alu_op     = ALU_OP_ADD;
                s.sel_wr_reg = 1'b1;
                s.sel_alu_b  = 1'b1;
            end
            OP_T: begin
                s.sel_wr_reg  = 1'b1;
                s.sel_wr_data = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles without an instruction-memory ack and flags the cycle in
// which the wait budget is exhausted. Only built when IM_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in_fetch,
    input  logic i_im_ack,
    output logic o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wait_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (!i_in_fetch) begin
            r_wait_cnt <= '0;
        end else if (!i_im_ack) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // A late ack in the final cycle still wins over the timeout.
    assign o_timeout = i_in_fetch && !i_im_ack && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with J, HALT and illegal-opcode trap paths.
// Optional instruction-fetch timeout is enabled by defining IM_TIMEOUT_EN.
module multicycle_controller
    import proc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16
`ifdef IM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [4:0]          i_opcode,
    input  logic                i_im_ack,
    output logic                o_im_req,
    output logic                o_ir_load,
    output logic                o_pc_inc,
    output logic                o_pc_jump,
    output logic                o_reg_write,
    output logic [3:0]          o_alu_op,
    output logic                o_sel_wr_reg,
    output logic                o_sel_wr_data,
    output logic                o_sel_alu_b,
    output logic                o_halted,
    output logic                o_trap,
    output logic [RETIRE_W-1:0] o_instr_retired
);

    state_t              r_state;
    state_t              w_next;
    ctrl_sel_t           r_sel;
    ctrl_sel_t           w_sel;
    logic                r_im_req;
    logic                r_wb;
    logic                r_pc_jump;
    logic                r_halted;
    logic                r_trap;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_timeout;
    logic                w_halt_dec;
    logic                w_retire;

`ifdef IM_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fetch_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_in_fetch (r_state == FETCH),
        .i_im_ack   (i_im_ack),
        .o_timeout  (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign w_halt_dec = (r_state == DECODE) && (i_opcode == OP_HALT);
    assign w_retire   = (r_state == WB) || (r_state == JUMP) || w_halt_dec;

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = FETCH;
            FETCH: begin
                if (i_im_ack)       w_next = DECODE;
                else if (w_timeout) w_next = TRAP;
            end
            DECODE: begin
                case (i_opcode)
                    OP_AR, OP_I: w_next = EXEC;
                    OP_T:        w_next = WB;
                    OP_J:        w_next = JUMP;
                    OP_HALT:     w_next = HALTED;
                    default:     w_next = TRAP;
                endcase
            end
            EXEC:    w_next = WB;
            WB:      w_next = FETCH;
            JUMP:    w_next = FETCH;
            HALTED:  if (i_start) w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = IDLE;
        endcase
    end

    // Selects come straight from the opcode in DECODE, then are held from the register.
    assign w_sel = (r_state == DECODE) ? decode_sel(i_opcode) : r_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: every control register is reset so an async reset never leaves a write pulse behind.
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_im_req  <= 1'b0;
            r_wb      <= 1'b0;
            r_pc_jump <= 1'b0;
            r_halted  <= 1'b0;
            r_trap    <= 1'b0;
            r_retired <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            r_state   <= w_next;
            r_im_req  <= (w_next == FETCH);
            r_wb      <= (w_next == WB);
            r_pc_jump <= (w_next == JUMP);
            r_halted  <= (w_next == HALTED);
            r_trap    <= (w_next == TRAP);
            r_sel     <= ((w_next == EXEC) || (w_next == WB)) ? w_sel : '0;
            if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    assign o_im_req        = r_im_req;
    assign o_ir_load       = r_im_req && i_im_ack;
    assign o_pc_inc        = r_wb || w_halt_dec;
    assign o_pc_jump       = r_pc_jump;
    assign o_reg_write     = r_wb;
    assign o_alu_op        = w_sel.alu_op;
    assign o_sel_wr_reg    = w_sel.sel_wr_reg;
    assign o_sel_wr_data   = w_sel.sel_wr_data;
    assign o_sel_alu_b     = w_sel.sel_alu_b;
    assign o_halted        = r_halted;
    assign o_trap          = r_trap;
    assign o_instr_retired = r_retired;

endmodule
